// File: rtl/tlul_arb_pkg.sv
// tlul_arb_pkg: lock-state enum and host-index sizing for tlul_mem_arbiter
package tlul_arb_pkg;
  typedef enum logic {IDLE, HOLD} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int DefNumHosts = 4;
  typedef logic [idx_w(DefNumHosts)-1:0] host_idx_t;
endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL A/D channel structs shared by hosts, arbiter and memory bridge
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/tlul_arb_idx_fifo.sv
// tlul_arb_idx_fifo: synchronous FIFO (power-of-2 depth) with full/empty flags and occupancy count
module tlul_arb_idx_fifo #(
  parameter int Width = 2,
  parameter int Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);
  localparam int AW = $clog2(Depth);
  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end
  assign data_o  = mem_q[rptr_q];
  assign full_o  = cnt_q == (AW+1)'(Depth);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/tlul_mem_arbiter.sv
// tlul_mem_arbiter: round-robin TL-UL host arbiter onto one memory port, in-order response routing.
// Define TLUL_ARB_PERF_EN to build per-host accepted-request counters.
module tlul_mem_arbiter
  import tlul_arb_pkg::*;
#(
  parameter int NumHosts       = 4,
  parameter int MaxOutstanding = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  tlul_pkg::tl_h2d_t               tl_h_i [NumHosts],
  output tlul_pkg::tl_d2h_t               tl_h_o [NumHosts],
  output tlul_pkg::tl_h2d_t               tl_d_o,
  input  tlul_pkg::tl_d2h_t               tl_d_i,
  output logic [$clog2(MaxOutstanding):0] outstanding_o,
  output logic                            err_o,
  output logic [31:0]                     grant_cnt_o [NumHosts]
);
  localparam int IW = idx_w(NumHosts);
  typedef logic [IW-1:0] idx_t;
  localparam idx_t LastIdx = idx_t'(NumHosts - 1);
  arb_state_e state_q, state_d;
  idx_t rr_q, rr_d, lock_q, lock_d, arb_idx, cand, gnt, head;
  logic [NumHosts-1:0] req;
  logic err_q, err_d, full, empty, gv, accept, pop, found;
  always_comb begin
    for (int i = 0; i < NumHosts; i++) req[i] = tl_h_i[i].a_valid;
  end
  always_comb begin
    arb_idx = rr_q;
    found   = 1'b0;
    cand    = rr_q;
    for (int i = 0; i < NumHosts; i++) begin
      if (!found && req[cand]) begin
        found   = 1'b1;
        arb_idx = cand;
      end
      cand = (cand == LastIdx) ? '0 : cand + 1'b1;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end
  // A stalled request is pinned to its host so tl_d_o stays stable until accepted.
  always_comb begin
    state_d = (state_q == IDLE && tl_d_o.a_valid && !tl_d_i.a_ready) ? HOLD :
              (state_q == HOLD && accept) ? IDLE : state_q;
    lock_d  = (state_q == IDLE) ? gnt : lock_q;
  end
  always_comb begin
    gnt = (state_q == HOLD) ? lock_q : arb_idx;
  end
  assign gv     = req[gnt];
  assign accept = tl_d_o.a_valid && tl_d_i.a_ready;
  assign pop    = !empty && tl_d_i.d_valid && tl_d_o.d_ready;
  always_comb begin
    tl_d_o         = tl_h_i[gnt];
    tl_d_o.a_valid = gv && !full;
    tl_d_o.d_ready = empty ? 1'b1 : tl_h_i[head].d_ready;
    for (int i = 0; i < NumHosts; i++) begin
      tl_h_o[i] = '0;
      if (!empty && head == idx_t'(i)) tl_h_o[i] = tl_d_i;
      tl_h_o[i].a_ready = (gnt == idx_t'(i)) && gv && tl_d_i.a_ready && !full;
    end
  end
  always_comb begin
    rr_d  = accept ? ((gnt == LastIdx) ? '0 : gnt + 1'b1) : rr_q;
    err_d = err_q | (empty & tl_d_i.d_valid);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
  tlul_arb_idx_fifo #(
    .Width(IW),
    .Depth(MaxOutstanding)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (accept),
    .data_i (gnt),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(outstanding_o)
  );
`ifdef TLUL_ARB_PERF_EN
  logic [31:0] cnt_q [NumHosts];
  logic [31:0] cnt_d [NumHosts];
  always_comb begin
    for (int i = 0; i < NumHosts; i++) cnt_d[i] = cnt_q[i] + 32'(accept && gnt == idx_t'(i));
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumHosts; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumHosts; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  always_comb begin
    for (int i = 0; i < NumHosts; i++) grant_cnt_o[i] = cnt_q[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NumHosts; i++) grant_cnt_o[i] = '0;
  end
`endif
endmodule

// File: tb/tb_tlul_mem_arbiter.sv
// tb_tlul_mem_arbiter: directed checks of arbitration, lock, routing, full FIFO, spurious response and counters
module tb_tlul_mem_arbiter;
  import tlul_pkg::*;
  localparam int N = 4;
  localparam int PerfExp =
`ifdef TLUL_ARB_PERF_EN
    3;
`else
    0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  tl_h2d_t h_i [N];
  tl_d2h_t h_o [N];
  tl_h2d_t d_o;
  tl_d2h_t d_i;
  logic [3:0] out_cnt;
  logic err;
  logic [31:0] gcnt [N];
  logic [N-1:0] av, dv;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  tlul_mem_arbiter #(.NumHosts(N), .MaxOutstanding(8)) dut (
    .clk_i(clk), .rst_i(rst), .tl_h_i(h_i), .tl_h_o(h_o), .tl_d_o(d_o), .tl_d_i(d_i),
    .outstanding_o(out_cnt), .err_o(err), .grant_cnt_o(gcnt)
  );
  always_comb begin
    for (int i = 0; i < N; i++) begin
      av[i] = h_o[i].a_ready;
      dv[i] = h_o[i].d_valid;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic look;
    @(negedge clk);
  endtask
  task automatic req(input int h, input logic v);
    h_i[h].a_valid   = v;
    h_i[h].a_source  = 8'h10 + 8'(h);
    h_i[h].a_address = 32'h1000 * h;
    h_i[h].a_opcode  = 3'd4;
    h_i[h].d_ready   = 1'b1;
  endtask
  task automatic resp(input int h, input int left);
    d_i.d_valid  = 1'b1;
    d_i.d_source = 8'h10 + 8'(h);
    look;
    chk("rsp_route", 32'(dv), 1 << h);
    chk("rsp_src", 32'(h_o[h].d_source), 32'h10 + h);
    chk("rsp_dready", 32'(d_o.d_ready), 1);
    chk("rsp_out", 32'(out_cnt), left);
    tick;
    d_i.d_valid = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < N; i++) h_i[i] = '0;
    d_i = '0;
    repeat (2) tick;
    rst = 1'b0;
    look;
    chk("rst_out", 32'(out_cnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ardy", 32'(av), 0);
    chk("rst_dval", 32'(dv), 0);
    chk("rst_avalid", 32'(d_o.a_valid), 0);
    chk("rst_cnt", gcnt[2], 0);
    tick;
    d_i.a_ready = 1'b1;
    for (int h = 0; h < N; h++) req(h, 1'b1);
    for (int k = 0; k < 5; k++) begin
      look;
      chk("rr_src", 32'(d_o.a_source), 32'h10 + (k % N));
      chk("rr_ardy", 32'(av), 1 << (k % N));
      chk("rr_out", 32'(out_cnt), k);
      tick;
    end
    for (int h = 0; h < N; h++) req(h, 1'b0);
    resp(0, 5); resp(1, 4); resp(2, 3); resp(3, 2); resp(0, 1);
    look;
    chk("drain_out", 32'(out_cnt), 0);
    tick;
    req(2, 1'b1);
    look;
    chk("pre_src", 32'(d_o.a_source), 32'h12);
    tick;
    d_i.a_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      look;
      chk("lock_src", 32'(d_o.a_source), 32'h12);
      chk("lock_vld", 32'(d_o.a_valid), 1);
      chk("lock_ardy", 32'(av), 0);
      tick;
      req(0, 1'b1);
    end
    d_i.a_ready = 1'b1;
    look;
    chk("lock_rel_src", 32'(d_o.a_source), 32'h12);
    chk("lock_rel_ardy", 32'(av), 4);
    tick;
    req(2, 1'b0);
    look;
    chk("after_src", 32'(d_o.a_source), 32'h10);
    chk("after_ardy", 32'(av), 1);
    tick;
    req(0, 1'b0);
    resp(2, 3); resp(2, 2); resp(0, 1);
    req(1, 1'b1);
    look;
    chk("r1_ardy", 32'(av), 2);
    tick;
    req(1, 1'b0);
    req(3, 1'b1);
    look;
    chk("r3_ardy", 32'(av), 8);
    tick;
    req(3, 1'b0);
    h_i[1].d_ready = 1'b0;
    d_i.d_valid  = 1'b1;
    d_i.d_source = 8'h11;
    look;
    chk("bp_route", 32'(dv), 2);
    chk("bp_dready", 32'(d_o.d_ready), 0);
    tick;
    h_i[1].d_ready = 1'b1;
    resp(1, 2); resp(3, 1);
    req(0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      look;
      chk("fill_ardy", 32'(av), 1);
      tick;
    end
    d_i.d_valid  = 1'b1;
    d_i.d_source = 8'h10;
    look;
    chk("full_ardy", 32'(av), 0);
    chk("full_avalid", 32'(d_o.a_valid), 0);
    chk("full_out", 32'(out_cnt), 8);
    chk("full_pop", 32'(dv), 1);
    tick;
    d_i.d_valid = 1'b0;
    look;
    chk("refill_ardy", 32'(av), 1);
    chk("refill_out", 32'(out_cnt), 7);
    tick;
    req(0, 1'b0);
    for (int k = 0; k < 8; k++) resp(0, 8 - k);
    look;
    chk("empty_out", 32'(out_cnt), 0);
    tick;
    d_i.d_valid = 1'b1;
    look;
    chk("spur_dval", 32'(dv), 0);
    chk("spur_dready", 32'(d_o.d_ready), 1);
    chk("spur_err_pre", 32'(err), 0);
    tick;
    d_i.d_valid = 1'b0;
    look;
    chk("spur_err", 32'(err), 1);
    tick;
    look;
    chk("spur_err_sticky", 32'(err), 1);
    rst = 1'b1;
    #1;
    chk("arst_err", 32'(err), 0);
    tick;
    rst = 1'b0;
    req(2, 1'b1);
    repeat (3) tick;
    req(2, 1'b0);
    look;
    chk("perf_cnt2", gcnt[2], PerfExp);
    chk("perf_cnt0", gcnt[0], 0);
    chk("perf_cnt1", gcnt[1], 0);
    chk("perf_cnt3", gcnt[3], 0);
    chk("perf_out", 32'(out_cnt), 3);
    tick;
    resp(2, 3); resp(2, 2); resp(2, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
